// File: rtl/gpu_sched_pkg.sv
// Shared types and constants for the work dispatcher: core FSM states,
// idle status encodings and default datapath widths.
package gpu_sched_pkg;

   localparam int DEF_PC_W  = 16;
   localparam int DEF_QID_W = 4;

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      WAIT  = 2'b01,
      GRANT = 2'b10
   } core_state_t;

   localparam logic [1:0] IDLE_RUNNING = 2'b00;
   localparam logic [1:0] IDLE_WAITING = 2'b01;
   localparam logic [1:0] IDLE_HALTED  = 2'b10;

endpackage

// File: rtl/work_dispatcher_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves past the winner only when advance_i is high.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req_i,
   input  logic         advance_i,
   output logic [N-1:0] gnt_o
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q, ptr_d;
   logic          found_s;
   int            idx_s, win_s;

   // Search from the pointer for the first requester
   always_comb begin
      found_s = 1'b0;
      idx_s   = 0;
      win_s   = 0;
      for (int off = 0; off < N; off++) begin
         idx_s = (int'(ptr_q) + off) % N;
         if (!found_s && req_i[idx_s]) begin
            found_s = 1'b1;
            win_s   = idx_s;
         end else begin
            win_s   = win_s;
         end
      end
      gnt_o = found_s ? (N'(1) << win_s) : '0;
      if (found_s && advance_i) begin
         ptr_d = PW'((win_s + 1) % N);
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Priority pointer register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/work_dispatcher.sv
// Central work dispatcher: merges host/core queue pushes into a pending FIFO and
// hands start PCs to waiting cores round-robin. DISPATCH_STATS_EN adds counters.
module work_dispatcher
   import gpu_sched_pkg::*;
#(
   parameter int NUM_CORES  = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int PC_W       = DEF_PC_W,
   parameter int QID_W      = DEF_QID_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         host_wen,
   input  logic [QID_W-1:0]             host_qid,
   output logic                         host_ready,
   input  logic                         cfg_wen,
   input  logic [QID_W-1:0]             cfg_qid,
   input  logic [PC_W-1:0]              cfg_pc,
   input  logic [NUM_CORES-1:0]         queue_wen,
   input  logic [NUM_CORES*QID_W-1:0]   queue_number,
   input  logic [NUM_CORES-1:0]         request_new_pc,
   output logic [NUM_CORES*PC_W-1:0]    new_pc,
   output logic [NUM_CORES-1:0]         pc_valid,
   output logic [NUM_CORES*2-1:0]       idle,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
   output logic                         overflow
`ifdef DISPATCH_STATS_EN
   ,
   output logic [31:0]                  stat_dispatched,
   output logic [31:0]                  stat_starve
`endif
);

   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int TBL = 2 ** QID_W;

   logic [QID_W-1:0]          fifo_mem_q [FIFO_DEPTH];
   logic [AW-1:0]             wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]             count_q, count_d;
   logic [PC_W-1:0]           table_q [TBL];
   logic [NUM_CORES-1:0]      stage_v_q, stage_v_d;
   logic [QID_W-1:0]          stage_qid_q [NUM_CORES];
   logic [QID_W-1:0]          stage_qid_d [NUM_CORES];
   core_state_t               state_q [NUM_CORES];
   core_state_t               state_d [NUM_CORES];
   logic [NUM_CORES*PC_W-1:0] new_pc_q, new_pc_d;
   logic [NUM_CORES-1:0]      pc_valid_q, pc_valid_d;
   logic                      overflow_q, ovf_set_s;

   logic                      full_s, empty_s, host_push_s, stage_adv_s, push_s, pop_s, halted_s;
   logic [NUM_CORES-1:0]      stage_gnt_s, drained_s, wait_vec_s, disp_gnt_s;
   logic [QID_W-1:0]          push_qid_s;
   logic [PC_W-1:0]           head_pc_s;

   assign full_s      = (count_q == CW'(FIFO_DEPTH));
   assign empty_s     = (count_q == '0);
   assign host_push_s = host_wen & ~full_s;
   assign stage_adv_s = ~full_s & ~host_wen & (|stage_v_q);
   assign drained_s   = stage_adv_s ? stage_gnt_s : '0;
   assign push_s      = host_push_s | stage_adv_s;
   assign pop_s       = ~empty_s & (|wait_vec_s);
   assign head_pc_s   = table_q[fifo_mem_q[rd_ptr_q]];

   rr_arbiter #(.N(NUM_CORES)) u_push_arb (
      .clk       (clk),
      .rst       (rst),
      .req_i     (stage_v_q),
      .advance_i (stage_adv_s),
      .gnt_o     (stage_gnt_s)
   );

   rr_arbiter #(.N(NUM_CORES)) u_disp_arb (
      .clk       (clk),
      .rst       (rst),
      .req_i     (wait_vec_s),
      .advance_i (pop_s),
      .gnt_o     (disp_gnt_s)
   );

   // FIFO write data and staging-register updates
   always_comb begin
      push_qid_s = '0;
      stage_v_d  = stage_v_q;
      stage_qid_d = stage_qid_q;
      ovf_set_s  = 1'b0;
      if (host_push_s) begin
         push_qid_s = host_qid;
      end else begin
         for (int i = 0; i < NUM_CORES; i++) begin
            push_qid_s = push_qid_s | (stage_gnt_s[i] ? stage_qid_q[i] : '0);
         end
      end
      for (int i = 0; i < NUM_CORES; i++) begin
         if (queue_wen[i] && (!stage_v_q[i] || drained_s[i])) begin
            stage_v_d[i]   = 1'b1;
            stage_qid_d[i] = queue_number[i*QID_W +: QID_W];
         end else if (queue_wen[i]) begin
            ovf_set_s = 1'b1;
         end else if (drained_s[i]) begin
            stage_v_d[i] = 1'b0;
         end else begin
            stage_v_d[i] = stage_v_q[i];
         end
      end
   end

   // Per-core FSM next state and grant outputs
   always_comb begin
      new_pc_d   = new_pc_q;
      pc_valid_d = pop_s ? disp_gnt_s : '0;
      count_d    = count_q + CW'(push_s) - CW'(pop_s);
      for (int i = 0; i < NUM_CORES; i++) begin
         wait_vec_s[i] = (state_q[i] == WAIT);
         case (state_q[i])
            RUN:     state_d[i] = request_new_pc[i] ? WAIT : RUN;
            WAIT:    state_d[i] = (pop_s && disp_gnt_s[i]) ? GRANT : WAIT;
            GRANT:   state_d[i] = RUN;
            default: state_d[i] = WAIT;
         endcase
         if (pop_s && disp_gnt_s[i]) begin
            new_pc_d[i*PC_W +: PC_W] = head_pc_s;
         end else begin
            new_pc_d[i*PC_W +: PC_W] = new_pc_q[i*PC_W +: PC_W];
         end
      end
   end

   // Halted only when nothing anywhere could produce work this cycle
   always_comb begin
      halted_s = ~rst & (&wait_vec_s) & empty_s & ~(|stage_v_q) & ~host_wen;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (halted_s) begin
            idle[2*i +: 2] = IDLE_HALTED;
         end else if (wait_vec_s[i]) begin
            idle[2*i +: 2] = IDLE_WAITING;
         end else begin
            idle[2*i +: 2] = IDLE_RUNNING;
         end
      end
   end

   // Control state, start-PC table and grant registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         stage_v_q  <= '0;
         new_pc_q   <= '0;
         pc_valid_q <= '0;
         overflow_q <= 1'b0;
         for (int i = 0; i < TBL; i++) table_q[i] <= '0;
         for (int i = 0; i < NUM_CORES; i++) begin
            state_q[i]     <= WAIT;
            stage_qid_q[i] <= '0;
         end
      end else begin
         wr_ptr_q   <= wr_ptr_q + AW'(push_s);
         rd_ptr_q   <= rd_ptr_q + AW'(pop_s);
         count_q    <= count_d;
         stage_v_q  <= stage_v_d;
         stage_qid_q <= stage_qid_d;
         new_pc_q   <= new_pc_d;
         pc_valid_q <= pc_valid_d;
         overflow_q <= overflow_q | ovf_set_s;
         state_q    <= state_d;
         if (cfg_wen) table_q[cfg_qid] <= cfg_pc;
      end
   end

   // FIFO storage carries no reset; occupancy is tracked by count_q
   always_ff @(posedge clk) begin
      if (push_s) fifo_mem_q[wr_ptr_q] <= push_qid_s;
   end

`ifdef DISPATCH_STATS_EN
   logic [31:0] stat_disp_q, stat_starve_q;

   // Saturating dispatch and starvation counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_disp_q   <= 32'd0;
         stat_starve_q <= 32'd0;
      end else begin
         if ((|pc_valid_q) && (stat_disp_q != 32'hFFFF_FFFF)) stat_disp_q <= stat_disp_q + 32'd1;
         if ((|wait_vec_s) && empty_s && (stat_starve_q != 32'hFFFF_FFFF)) stat_starve_q <= stat_starve_q + 32'd1;
      end
   end

   assign stat_dispatched = stat_disp_q;
   assign stat_starve     = stat_starve_q;
`endif

   assign host_ready = ~full_s;
   assign new_pc     = new_pc_q;
   assign pc_valid   = pc_valid_q;
   assign fifo_count = count_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_work_dispatcher.sv
// Directed bench for work_dispatcher: grants are checked by a scoreboard
// monitor, status outputs by inline comparisons against hand-derived values.
module tb_work_dispatcher;

   localparam int NC = 4;
   localparam int PCW = 16;
   localparam int QW = 4;
   localparam int DEPTH = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 host_wen;
   logic [QW-1:0]        host_qid;
   logic                 host_ready;
   logic                 cfg_wen;
   logic [QW-1:0]        cfg_qid;
   logic [PCW-1:0]       cfg_pc;
   logic [NC-1:0]        queue_wen;
   logic [NC*QW-1:0]     queue_number;
   logic [NC-1:0]        request_new_pc;
   logic [NC*PCW-1:0]    new_pc;
   logic [NC-1:0]        pc_valid;
   logic [NC*2-1:0]      idle;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                 overflow;
`ifdef DISPATCH_STATS_EN
   logic [31:0]          stat_dispatched, stat_starve;
`endif

   int tests = 0;
   int fails = 0;

   typedef struct {
      int         core;
      logic [15:0] pc;
   } exp_t;
   exp_t exp_q[$];

   work_dispatcher dut (
      .clk            (clk),
      .rst            (rst),
      .host_wen       (host_wen),
      .host_qid       (host_qid),
      .host_ready     (host_ready),
      .cfg_wen        (cfg_wen),
      .cfg_qid        (cfg_qid),
      .cfg_pc         (cfg_pc),
      .queue_wen      (queue_wen),
      .queue_number   (queue_number),
      .request_new_pc (request_new_pc),
      .new_pc         (new_pc),
      .pc_valid       (pc_valid),
      .idle           (idle),
      .fifo_count     (fifo_count),
      .overflow       (overflow)
`ifdef DISPATCH_STATS_EN
      ,
      .stat_dispatched (stat_dispatched),
      .stat_starve     (stat_starve)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic exp_push(input int core, input logic [15:0] pc);
      exp_t e;
      e.core = core;
      e.pc   = pc;
      exp_q.push_back(e);
   endtask

   task automatic cfg_write(input logic [QW-1:0] q, input logic [PCW-1:0] pc);
      cfg_wen = 1'b1;
      cfg_qid = q;
      cfg_pc  = pc;
      tick();
      cfg_wen = 1'b0;
   endtask

   // Scoreboard monitor: every grant strobe must match the oldest expectation
   always @(negedge clk) begin
      if (!rst && (|pc_valid)) begin
         check("grant_onehot", $countones(pc_valid), 1);
         for (int i = 0; i < NC; i++) begin
            if (pc_valid[i]) begin
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_grant: core %0d pc 0x%0h, none expected", i, new_pc[i*PCW +: PCW]);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  check("grant_core", i, e.core);
                  check("grant_pc", new_pc[i*PCW +: PCW], e.pc);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; host_wen = 1'b0; host_qid = '0; cfg_wen = 1'b0; cfg_qid = '0; cfg_pc = '0;
      queue_wen = '0; queue_number = '0; request_new_pc = '0;
      tick(); tick();
      check("rst_pc_valid", pc_valid, 0);
      check("rst_new_pc", new_pc[31:0], 0);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_overflow", overflow, 0);
      check("rst_host_ready", host_ready, 1);
      check("rst_idle", idle, 8'h55);
      rst = 1'b0;
      #1 check("halted_after_rst", idle, 8'hAA);

      // Single host item dispatched to core 0
      cfg_write(4'd3, 16'h0040);
      host_wen = 1'b1; host_qid = 4'd3;
      #1 check("idle_wake_same_cycle", idle, 8'h55);
      exp_push(0, 16'h0040);
      tick();
      host_wen = 1'b0;
      check("no_bypass_count", fifo_count, 1);
      check("no_bypass_valid", pc_valid, 0);
      tick();
      check("t1_pc_valid", pc_valid, 4'b0001);
      check("t1_new_pc0", new_pc[15:0], 16'h0040);
      check("t1_idle", idle, 8'h54);
      check("t1_fifo_empty", fifo_count, 0);

      // Put cores 1..3 into RUN
      cfg_write(4'd2, 16'h0200);
      host_wen = 1'b1; host_qid = 4'd2;
      for (int k = 1; k < NC; k++) exp_push(k, 16'h0200);
      tick(); tick(); tick();
      host_wen = 1'b0;
      tick(); tick(); tick(); tick();
      check("all_run_idle", idle, 8'h00);
      check("all_run_count", fifo_count, 0);

      // Four simultaneous core pushes enter one per cycle
      cfg_write(4'd1, 16'h0100);
      for (int k = 4; k < 8; k++) cfg_write(QW'(k), PCW'(k * 256));
      cfg_write(4'd9, 16'h0900);
      queue_number = 16'h7654; queue_wen = 4'hF;
      tick();
      queue_wen = '0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("stage_fill_count", fifo_count, k);
      end
      check("stage_fill_no_ovf", overflow, 0);

      // Fill FIFO, full host push ignored, staged core overflows
      host_wen = 1'b1; host_qid = 4'd1;
      tick(); tick(); tick(); tick();
      host_qid = 4'd11;
      tick();
      host_wen = 1'b0;
      check("full_count", fifo_count, 8);
      check("full_host_ready", host_ready, 0);
      queue_number = 16'h0900; queue_wen = 4'b0100;
      tick();
      check("first_push_staged", overflow, 0);
      queue_number = 16'h0A00;
      tick();
      queue_wen = '0;
      check("second_push_dropped", overflow, 1);
      check("full_count_hold", fifo_count, 8);

      // Cores 1 and 3 waiting: round-robin grants one cycle apart
      request_new_pc = 4'b1010;
      exp_push(1, 16'h0400);
      exp_push(3, 16'h0500);
      tick();
      request_new_pc = '0;
      check("wait13_idle", idle, 8'h44);
      tick();
      check("rr_first", pc_valid, 4'b0010);
      check("pop_count", fifo_count, 7);
      tick();
      check("rr_second", pc_valid, 4'b1000);
      check("push_pop_same_cycle", fifo_count, 7);
      check("ovf_sticky", overflow, 1);
      tick(); tick();
      check("staged_entered", fifo_count, 7);

      // Next round resumes after core 3
      request_new_pc = 4'b1001;
      exp_push(0, 16'h0600);
      exp_push(3, 16'h0700);
      tick();
      request_new_pc = '0;
      tick();
      check("rr_wrap_core0", pc_valid, 4'b0001);
      tick();
      check("rr_wrap_core3", pc_valid, 4'b1000);
      tick(); tick();
      check("after_round_count", fifo_count, 5);

      // Drain: host qid1 items, then the staged core-2 item
      request_new_pc = 4'hF;
      for (int k = 0; k < NC; k++) exp_push(k, 16'h0100);
      tick();
      request_new_pc = '0;
      repeat (6) tick();
      check("drain_count", fifo_count, 1);
      request_new_pc = 4'hF;
      exp_push(0, 16'h0900);
      tick();
      request_new_pc = '0;
      tick(); tick();
      check("starve_idle", idle, 8'h54);
      check("starve_count", fifo_count, 0);
      request_new_pc = 4'b0001;
      tick();
      request_new_pc = '0;
      check("halted_idle", idle, 8'hAA);

      // Wake from halt, table write racing a pop, then reset mid-grant
      host_wen = 1'b1; host_qid = 4'd3;
      #1 check("halt_wake_idle", idle, 8'h55);
      exp_push(1, 16'h0040);
      tick();
      cfg_wen = 1'b1; cfg_qid = 4'd3; cfg_pc = 16'h0333;
      tick();
      host_wen = 1'b0; cfg_wen = 1'b0;
      check("race_pc_valid", pc_valid, 4'b0010);
      check("race_old_pc", new_pc[31:16], 16'h0040);
      check("race_count", fifo_count, 1);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rst_mid_pc_valid", pc_valid, 0);
      check("rst_mid_count", fifo_count, 0);
      check("rst_mid_idle", idle, 8'h55);
      check("rst_mid_overflow", overflow, 0);
      check("scoreboard_empty", exp_q.size(), 0);
      tick();
      rst = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
